// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control: FSM states, opcode/funct
// values and the mux-select / alu_op codes driven onto the datapath.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_SHIFT  = 4'd7,
    S_RWB    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_JR     = 4'd13,
    S_HALT   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_OPCODE = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JR     = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Instruction classifier: maps opcode/funct to the state that follows DECODE.
// Anything unrecognised lands in S_HALT and raises illegal.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_t     next_state,
  output logic       illegal
);

  always_comb begin
    next_state = S_HALT;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT: next_state = S_EXEC;
          F_SLL, F_SRL:                            next_state = S_SHIFT;
          F_JR:                                    next_state = S_JR;
          default:                                 next_state = S_HALT;
        endcase
      end
      OP_LW, OP_SW:             next_state = S_MEMADR;
      OP_BEQ, OP_BNE:           next_state = S_BRANCH;
      OP_J:                     next_state = S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI: next_state = S_IEXEC;
      default:                  next_state = S_HALT;
    endcase
    illegal = (next_state == S_HALT);
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS core: sequences the shared datapath
// over 3-5 cycles per instruction with a single wait-stated memory port.
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_eq,
  output logic       pc_write_ne,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       ext_zero,
  output logic       retired,
  output logic       halted,
  output logic [3:0] dbg_state,
  output logic       dbg_branch_taken
);

  // Memory handshake: mem_read/mem_write is a request held with a stable
  // i_or_d until mem_ready is seen high on a posedge; that edge completes it.

  state_t state_q, state_d;
  logic   halted_q, halted_d;
  state_t dec_next;
  logic   dec_illegal;

  mc_ctrl_decode u_decode (
    .opcode     (opcode),
    .funct      (funct),
    .next_state (dec_next),
    .illegal    (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = dec_next;
        if (dec_illegal) halted_d = 1'b1;
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC, S_SHIFT: state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    pc_source   = PCSRC_ALU;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RT;
    alu_op      = ALUOP_ADD;
    ext_zero    = 1'b0;
    retired     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retired    = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retired   = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = SRCA_RS;
        alu_op    = ALUOP_FUNCT;
      end
      S_SHIFT: begin
        alu_src_a = SRCA_SHAMT;
        alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retired   = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_IMM;
        if (opcode != OP_ADDI) begin
          alu_op   = ALUOP_OPCODE;
          ext_zero = 1'b1;
        end
      end
      S_IWB: begin
        reg_write = 1'b1;
        retired   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_RS;
        alu_op      = ALUOP_SUB;
        pc_source   = PCSRC_ALUOUT;
        pc_write_eq = (opcode == OP_BEQ);
        pc_write_ne = (opcode == OP_BNE);
        retired     = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        retired   = 1'b1;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JR;
        retired   = 1'b1;
      end
      default: ;
    endcase
    // Reset abandons the current instruction: nothing may be written this cycle.
    if (reset) begin
      pc_write    = 1'b0;
      pc_write_eq = 1'b0;
      pc_write_ne = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      retired     = 1'b0;
    end
  end

  assign halted           = halted_q;
  assign dbg_state        = state_q;
  assign dbg_branch_taken = (state_q == S_BRANCH) &&
                            ((pc_write_eq && zero) || (pc_write_ne && !zero));

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected control vectors from a
// reference model are queued by the driver and compared at each negedge.
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  localparam int W = 26;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_eq, pc_write_ne;
  logic [1:0] pc_source;
  logic       i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       ext_zero, retired, halted;
  logic [3:0] dbg_state;
  logic       dbg_branch_taken;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  int total = 0;
  int bad = 0;
  int ret_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_eq(pc_write_eq),
    .pc_write_ne(pc_write_ne), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .ext_zero(ext_zero), .retired(retired), .halted(halted),
    .dbg_state(dbg_state), .dbg_branch_taken(dbg_branch_taken)
  );

  assign obs = {dbg_state, pc_write, pc_write_eq, pc_write_ne, pc_source, i_or_d,
                mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                alu_src_a, alu_src_b, alu_op, ext_zero, retired, halted,
                dbg_branch_taken};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Reference model: control outputs expected in a given state.
  function automatic logic [W-1:0] model(input state_t st, input logic [5:0] op,
                                         input logic mr, input logic rst, input logic z);
    logic pw, peq, pne, iod, mrd, mwr, irw, m2r, rd, rw, ez, ret, hlt, tk;
    logic [1:0] ps, sa, sb, ao;
    {pw, peq, pne, iod, mrd, mwr, irw, m2r, rd, rw, ez, ret} = '0;
    ps = 2'b00; sa = 2'b00; sb = 2'b00; ao = 2'b00;
    hlt = (st == S_HALT);
    case (st)
      S_FETCH:  begin mrd = 1; sb = 2'b01; pw = mr; irw = mr; end
      S_DECODE: sb = 2'b11;
      S_MEMADR: begin sa = 2'b01; sb = 2'b10; end
      S_MEMRD:  begin mrd = 1; iod = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; ret = 1; end
      S_MEMWR:  begin mwr = 1; iod = 1; ret = mr; end
      S_EXEC:   begin sa = 2'b01; ao = 2'b10; end
      S_SHIFT:  begin sa = 2'b10; ao = 2'b10; end
      S_RWB:    begin rw = 1; rd = 1; ret = 1; end
      S_IEXEC:  begin
        sa = 2'b01; sb = 2'b10;
        if (op == OP_ANDI || op == OP_ORI) begin ao = 2'b11; ez = 1; end
      end
      S_IWB:    begin rw = 1; ret = 1; end
      S_BRANCH: begin
        sa = 2'b01; ao = 2'b01; ps = 2'b01; ret = 1;
        peq = (op == OP_BEQ); pne = (op == OP_BNE);
      end
      S_JUMP:   begin pw = 1; ps = 2'b10; ret = 1; end
      S_JR:     begin pw = 1; ps = 2'b11; ret = 1; end
      default: ;
    endcase
    tk = (st == S_BRANCH) && ((op == OP_BEQ && z) || (op == OP_BNE && !z));
    if (rst) {pw, peq, pne, mrd, mwr, irw, rw, ret} = '0;
    return {st, pw, peq, pne, ps, iod, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao,
            ez, ret, hlt, tk};
  endfunction

  // scoreboard side
  always @(negedge clk) begin
    if (retired === 1'b1) ret_cnt++;
    if (exp_q.size() != 0) check("cycle", 32'(obs), 32'(exp_q.pop_front()));
  end

  // driver tasks
  task automatic step(input state_t st, input logic mr);
    mem_ready = mr;
    exp_q.push_back(model(st, opcode, mr, reset, zero));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fwait, input int mwait);
    int rc0;
    logic hlt;
    opcode = op; funct = fn; zero = z; reset = 1'b0;
    rc0 = ret_cnt; hlt = 1'b0;
    for (int i = 0; i < fwait; i++) step(S_FETCH, 1'b0);
    step(S_FETCH, 1'b1);
    step(S_DECODE, 1'b1);
    case (op)
      OP_LW: begin
        step(S_MEMADR, 1'b1);
        for (int i = 0; i < mwait; i++) step(S_MEMRD, 1'b0);
        step(S_MEMRD, 1'b1);
        step(S_MEMWB, 1'b1);
      end
      OP_SW: begin
        step(S_MEMADR, 1'b1);
        for (int i = 0; i < mwait; i++) step(S_MEMWR, 1'b0);
        step(S_MEMWR, 1'b1);
      end
      OP_RTYPE: begin
        case (fn)
          F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT: begin step(S_EXEC, 1'b1); step(S_RWB, 1'b1); end
          F_SLL, F_SRL: begin step(S_SHIFT, 1'b1); step(S_RWB, 1'b1); end
          F_JR:         step(S_JR, 1'b1);
          default:      hlt = 1'b1;
        endcase
      end
      OP_BEQ, OP_BNE:           step(S_BRANCH, 1'b1);
      OP_J:                     step(S_JUMP, 1'b1);
      OP_ADDI, OP_ANDI, OP_ORI: begin step(S_IEXEC, 1'b1); step(S_IWB, 1'b1); end
      default:                  hlt = 1'b1;
    endcase
    check("retired_count", 32'(ret_cnt - rc0), hlt ? 32'd0 : 32'd1);
  endtask

  task automatic halt_and_recover(input int cycles);
    for (int i = 0; i < cycles; i++) step(S_HALT, 1'b1);
    reset = 1'b1;
    step(S_HALT, 1'b1);
    reset = 1'b0;
  endtask

  logic [11:0] legal_tbl [12];

  initial begin
    legal_tbl = '{{OP_RTYPE, F_ADD}, {OP_RTYPE, F_SUB}, {OP_RTYPE, F_NOR},
                  {OP_RTYPE, F_SLT}, {OP_RTYPE, F_SRL}, {OP_RTYPE, F_JR},
                  {OP_LW, 6'd0}, {OP_SW, 6'd0}, {OP_BEQ, 6'd0},
                  {OP_J, 6'd0}, {OP_ADDI, 6'd0}, {OP_ANDI, 6'd0}};
    reset = 1'b1; opcode = OP_RTYPE; funct = F_ADD; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step(S_FETCH, 1'b1);
    reset = 1'b0;

    run_instr(OP_RTYPE, F_ADD, 1'b0, 0, 0);
    run_instr(OP_LW, 6'd0, 1'b0, 0, 3);
    run_instr(OP_SW, 6'd0, 1'b0, 2, 2);
    run_instr(OP_BNE, 6'd0, 1'b0, 0, 0);
    run_instr(OP_BNE, 6'd0, 1'b1, 0, 0);
    run_instr(OP_BEQ, 6'd0, 1'b1, 0, 0);
    run_instr(OP_ORI, 6'd0, 1'b0, 0, 0);
    run_instr(OP_ADDI, 6'd0, 1'b0, 0, 0);
    run_instr(OP_RTYPE, F_SLL, 1'b0, 0, 0);
    run_instr(OP_RTYPE, F_JR, 1'b0, 0, 0);
    run_instr(OP_J, 6'd0, 1'b0, 1, 0);

    run_instr(6'b111111, 6'd0, 1'b0, 0, 0);
    halt_and_recover(20);
    run_instr(OP_RTYPE, F_ADD, 1'b0, 0, 0);
    run_instr(OP_RTYPE, 6'b111111, 1'b0, 0, 0);
    halt_and_recover(3);

    // reset while waiting on a data read
    opcode = OP_LW; funct = 6'd0;
    step(S_FETCH, 1'b1);
    step(S_DECODE, 1'b1);
    step(S_MEMADR, 1'b1);
    step(S_MEMRD, 1'b0);
    reset = 1'b1;
    step(S_MEMRD, 1'b0);
    reset = 1'b0;
    run_instr(OP_ORI, 6'd0, 1'b0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [11:0] e;
      e = legal_tbl[$urandom_range(0, 11)];
      run_instr(e[11:6], e[5:0], 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
